pulse_req_arbiter: RTL

- Shares one downstream resource between N level-driven requesters (buttons, switches, status lines).
- Each request line passes through its own rising-edge detector. A detected edge is latched as a pending request.
- A round-robin scheduler grants the resource to one pending channel at a time. The grant is held until the resource signals done or a timeout expires.
- Sits between raw level inputs and any single-user datapath that must see one clean, one-hot grant per request edge.

---
 rtl/pulse_req_arbiter_pkg.sv | 13 +
 rtl/pulse_req_arbiter_rise.sv | 23 ++
 rtl/pulse_req_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pulse_req_arbiter_pkg.sv
// Shared definitions for the pulse request arbiter: FSM encoding and default sizing.
package pulse_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int DEF_N   = 4;
  localparam int DEF_TMO = 15;

endpackage

// File: rtl/pulse_req_arbiter_rise.sv
// Single-channel rising-edge detector; the previous level clears to zero so a level
// already high when reset releases is treated as a fresh edge.
module rise_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Previous-level register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/pulse_req_arbiter.sv
// Round-robin arbiter turning per-channel request edges into one-hot grants held
// until done or timeout, with a mandatory idle cycle between grants.
module pulse_req_arbiter
  import pulse_req_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int TMO = DEF_TMO,
  parameter int TW  = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req_level,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [N-1:0] pending,
  output logic         timeout_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  w_rise;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  w_grant_nxt;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_sel_onehot;
  logic          r_grant_valid;
  logic          r_timeout_err;
  logic          w_tmo_nxt;
  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [PW-1:0] r_rr;
  logic [PW-1:0] w_rr_nxt;
  logic [PW-1:0] w_sel;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_nxt;

  // First set bit at or after ptr, wrapping past N-1 back to 0
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          hit;
    sel = ptr;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!hit && req[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    rise_detect u_rise (
      .i_clock (clock),
      .i_reset (reset),
      .i_level (req_level[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  assign w_sel        = rr_pick(r_pending, r_rr);
  assign w_sel_onehot = {{(N-1){1'b0}}, 1'b1} << w_sel;

  // Pending flags: a new edge wins over the clear from the granting edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rr          <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= |w_grant_nxt;
      r_timeout_err <= w_tmo_nxt;
      r_rr          <= w_rr_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  // Next-state logic: schedule in IDLE, hold in BUSY, one forced idle cycle in GAP
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_tmo_nxt   = 1'b0;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_cnt;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_grant_nxt = w_sel_onehot;
          w_clr       = w_sel_onehot;
          w_rr_nxt    = (w_sel == PW'(N - 1)) ? '0 : w_sel + 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_BUSY;
        end else begin
          w_grant_nxt = '0;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (done) begin
          w_grant_nxt = '0;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == TW'(TMO - 1)) begin
          w_grant_nxt = '0;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_grant_nxt = r_grant;
        end
      end
      ST_GAP: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign pending     = r_pending;
  assign timeout_err = r_timeout_err;

endmodule
